flash_boot_loader: RTL and testbench

Boot-time stage sitting directly upstream of the SoC core on the FPGA top. After reset it reads a program image from the configuration SPI flash with a standard READ (0x03) command and writes it word by word into instruction memory through a write port. Core reset stays asserted until the image is in place. The flash SCLK it drives is the same net routed to the FPGA's user-clock configuration primitive.

---
 rtl/flash_boot_loader.sv | 220 ++++++++++++++++++++++
 tb/tb_flash_boot_loader.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flash_boot_loader.sv
// -----------------------------------------------------------------------------
// flash_boot_loader
//
// Boot-time loader. After reset it issues a SPI READ (0x03) to the
// configuration flash at FLASH_BASE, streams the image back in SPI mode 0 and
// writes it word by word into instruction memory. The core is held in reset
// until the whole image has been written.
//
// Optional feature macro: BOOT_CHECKSUM_EN
//   defined   : one extra trailing word is read and compared with the 32-bit
//               wrap-around sum of the image words; mismatch -> ERROR.
//   undefined : exactly IMEM_DEPTH words are read, o_boot_error is tied low.
//
// Ports
//   clk            core clock (single domain)
//   reset          synchronous, active-high reset
//   o_flash_sclk   SPI clock, idles low
//   o_flash_cs_n   flash chip select, active low
//   o_flash_mosi   command/address bits, MSB first
//   i_flash_miso   flash read data
//   o_imem_we      one-cycle IMEM write strobe per word
//   o_imem_addr    IMEM word address
//   o_imem_wdata   IMEM write data (little-endian byte assembly)
//   o_core_reset_n core reset, released after a successful load
//   o_boot_done    load finished successfully (sticky)
//   o_boot_error   checksum mismatch (sticky)
// -----------------------------------------------------------------------------
module flash_boot_loader #(
   parameter int          IMEM_DEPTH = 128,
   parameter logic [23:0] FLASH_BASE = 24'h300000,
   parameter int          SCLK_DIV   = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   output logic                          o_flash_sclk,
   output logic                          o_flash_cs_n,
   output logic                          o_flash_mosi,
   input  logic                          i_flash_miso,
   output logic                          o_imem_we,
   output logic [$clog2(IMEM_DEPTH)-1:0] o_imem_addr,
   output logic [31:0]                   o_imem_wdata,
   output logic                          o_core_reset_n,
   output logic                          o_boot_done,
   output logic                          o_boot_error
);

   localparam int AW = $clog2(IMEM_DEPTH);
`ifdef BOOT_CHECKSUM_EN
   localparam int NWORDS = IMEM_DEPTH + 1;
`else
   localparam int NWORDS = IMEM_DEPTH;
`endif
   localparam int            TOTAL_BITS = 32 + 32 * NWORDS;
   localparam logic [31:0]   LAST_BIT   = 32'(TOTAL_BITS - 1);
   localparam logic [31:0]   HALF_END   = 32'(SCLK_DIV - 1);
   localparam logic [31:0]   BIT_END    = 32'(2 * SCLK_DIV - 1);
   localparam logic [31:0]   CMD_ADDR   = {8'h03, FLASH_BASE};
   localparam logic [AW-1:0] LAST_ADDR  = AW'(IMEM_DEPTH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_CS_SETUP, S_CMD, S_ADDR, S_DATA, S_CS_HOLD, S_DONE, S_ERROR
   } state_t;

   state_t        state_q;
   logic [31:0]   div_q;     // clk cycles into the current SCLK period
   logic [31:0]   bit_q;     // index of the SCLK bit in progress (cmd+addr+data)
   logic [31:0]   tx_q;      // remaining command/address bits
   logic [31:0]   rx_q;      // received bits, first bit ends up in the MSB
   logic          sclk_q;
   logic          cs_n_q;
   logic          mosi_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [31:0]   wdata_q;
   logic          core_rst_n_q;
   logic          done_q;
`ifdef BOOT_CHECKSUM_EN
   logic [31:0]   sum_q;
   logic          match_q;
   logic          error_q;
`endif

   logic [31:0] bit_d;
   logic [31:0] rx_d;
   logic [31:0] word_d;
   logic        word_end_d;

   assign bit_d  = bit_q + 32'd1;
   assign rx_d   = {rx_q[30:0], i_flash_miso};
   // Bytes arrive first-to-last, so the first byte sits in rx_d[31:24] and
   // must land in wdata[7:0].
   assign word_d = {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]};
   // Data bits start at index 32; a word completes on every 32nd of them.
   assign word_end_d = (bit_d >= 32'd32) && (bit_d[4:0] == 5'd31);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_IDLE;
         div_q        <= '0;
         bit_q        <= '0;
         tx_q         <= '0;
         rx_q         <= '0;
         sclk_q       <= 1'b0;
         cs_n_q       <= 1'b1;
         mosi_q       <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_rst_n_q <= 1'b0;
         done_q       <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         sum_q        <= '0;
         match_q      <= 1'b0;
         error_q      <= 1'b0;
`endif
      end else begin
         we_q <= 1'b0;
         // Advance after each write, but park on the last address.
         if (we_q && (addr_q != LAST_ADDR)) addr_q <= addr_q + AW'(1);

         case (state_q)
            S_IDLE: begin
               state_q <= S_CS_SETUP;
               cs_n_q  <= 1'b0;
               mosi_q  <= CMD_ADDR[31];
               tx_q    <= {CMD_ADDR[30:0], 1'b0};
               div_q   <= '0;
            end
            // The setup period doubles as the low phase of the first bit.
            S_CS_SETUP: begin
               if (div_q == HALF_END) begin
                  state_q <= S_CMD;
                  sclk_q  <= 1'b1;
                  div_q   <= '0;
                  bit_q   <= '0;
               end else begin
                  div_q <= div_q + 32'd1;
               end
            end
            // Each bit is a high half followed by a low half; MOSI changes at
            // the falling edge, MISO is captured on the edge that raises SCLK.
            S_CMD, S_ADDR, S_DATA: begin
               if (div_q == HALF_END) begin
                  sclk_q <= 1'b0;
                  mosi_q <= tx_q[31];
                  tx_q   <= {tx_q[30:0], 1'b0};
                  div_q  <= div_q + 32'd1;
               end else if (div_q == BIT_END) begin
                  div_q <= '0;
                  if (bit_q == LAST_BIT) begin
                     state_q <= S_CS_HOLD;
                  end else begin
                     sclk_q <= 1'b1;
                     bit_q  <= bit_d;
                     if (bit_d == 32'd8)  state_q <= S_ADDR;
                     if (bit_d == 32'd32) state_q <= S_DATA;
                     if (bit_d >= 32'd32) rx_q <= rx_d;
                     if (word_end_d) begin
`ifdef BOOT_CHECKSUM_EN
                        if (bit_d == LAST_BIT) begin
                           match_q <= (word_d == sum_q);
                        end else begin
                           we_q    <= 1'b1;
                           wdata_q <= word_d;
                           sum_q   <= sum_q + word_d;
                        end
`else
                        we_q    <= 1'b1;
                        wdata_q <= word_d;
`endif
                     end
                  end
               end else begin
                  div_q <= div_q + 32'd1;
               end
            end
            S_CS_HOLD: begin
               if (div_q == HALF_END) begin
                  cs_n_q <= 1'b1;
                  div_q  <= '0;
`ifdef BOOT_CHECKSUM_EN
                  if (match_q) begin
                     state_q      <= S_DONE;
                     done_q       <= 1'b1;
                     core_rst_n_q <= 1'b1;
                  end else begin
                     state_q <= S_ERROR;
                     error_q <= 1'b1;
                  end
`else
                  state_q      <= S_DONE;
                  done_q       <= 1'b1;
                  core_rst_n_q <= 1'b1;
`endif
               end else begin
                  div_q <= div_q + 32'd1;
               end
            end
            S_DONE, S_ERROR: begin
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign o_flash_sclk   = sclk_q;
   assign o_flash_cs_n   = cs_n_q;
   assign o_flash_mosi   = mosi_q;
   assign o_imem_we      = we_q;
   assign o_imem_addr    = addr_q;
   assign o_imem_wdata   = wdata_q;
   assign o_core_reset_n = core_rst_n_q;
   assign o_boot_done    = done_q;
`ifdef BOOT_CHECKSUM_EN
   assign o_boot_error   = error_q;
`else
   assign o_boot_error   = 1'b0;
`endif

endmodule

// File: tb/tb_flash_boot_loader.sv
// -----------------------------------------------------------------------------
// Testbench for flash_boot_loader. Two instances share one clock:
//   dut0 : IMEM_DEPTH=128, SCLK_DIV=2 (command check, sequential image,
//          mid-transfer reset, random image, checksum error when enabled)
//   dut1 : IMEM_DEPTH=16,  SCLK_DIV=1 (boot cycle count and data)
// A behavioural flash per instance serves the image bit by bit from a byte
// array; expected IMEM writes are queued when an image is prepared and popped
// by a monitor on every write strobe.
// -----------------------------------------------------------------------------
module tb_flash_boot_loader;

   localparam int D0 = 128, DIV0 = 2, D1 = 16, DIV1 = 1;
`ifdef BOOT_CHECKSUM_EN
   localparam int XW = 1;
`else
   localparam int XW = 0;
`endif
   localparam int          NB0     = 4 * (D0 + XW);
   localparam int          NB1     = 4 * (D1 + XW);
   localparam logic [31:0] CMD_EXP = 32'h03300000;

   typedef struct {
      int          addr;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
      end
   endtask

   // ---------------- dut0 ----------------
   logic        reset0, sclk0, cs_n0, mosi0, we0, crn0, done0, err0;
   logic        miso0 = 1'b0;
   logic [6:0]  addr0;
   logic [31:0] wdata0;

   flash_boot_loader #(.IMEM_DEPTH(D0), .FLASH_BASE(24'h300000), .SCLK_DIV(DIV0)) dut0 (
      .clk(clk), .reset(reset0), .o_flash_sclk(sclk0), .o_flash_cs_n(cs_n0),
      .o_flash_mosi(mosi0), .i_flash_miso(miso0), .o_imem_we(we0), .o_imem_addr(addr0),
      .o_imem_wdata(wdata0), .o_core_reset_n(crn0), .o_boot_done(done0), .o_boot_error(err0));

   // ---------------- dut1 ----------------
   logic        reset1, sclk1, cs_n1, mosi1, we1, crn1, done1, err1;
   logic        miso1 = 1'b0;
   logic [3:0]  addr1;
   logic [31:0] wdata1;

   flash_boot_loader #(.IMEM_DEPTH(D1), .FLASH_BASE(24'h300000), .SCLK_DIV(DIV1)) dut1 (
      .clk(clk), .reset(reset1), .o_flash_sclk(sclk1), .o_flash_cs_n(cs_n1),
      .o_flash_mosi(mosi1), .i_flash_miso(miso1), .o_imem_we(we1), .o_imem_addr(addr1),
      .o_imem_wdata(wdata1), .o_core_reset_n(crn1), .o_boot_done(done1), .o_boot_error(err1));

   // ---------------- images and expectations ----------------
   logic [7:0] img0 [NB0];
   logic [7:0] img1 [NB1];
   exp_t       q0[$];
   exp_t       q1[$];
   int         wr0 = 0, wr1 = 0, base0 = 0;

   task automatic prep0(input bit rnd, input logic [31:0] bad);
      logic [31:0] sum, w;
      exp_t        e;
      sum = 32'd0;
      q0.delete();
      for (int i = 0; i < 4 * D0; i++) img0[i] = rnd ? 8'($urandom) : 8'(i);
      for (int k = 0; k < D0; k++) begin
         w = {img0[4*k+3], img0[4*k+2], img0[4*k+1], img0[4*k]};
         sum += w;
         e.addr = k;
         e.data = w;
         q0.push_back(e);
      end
`ifdef BOOT_CHECKSUM_EN
      for (int b = 0; b < 4; b++) img0[4*D0+b] = 8'((sum + bad) >> (8 * b));
`else
      if (bad != 32'd0) sum = 32'd0;
`endif
      base0 = wr0;
   endtask

   task automatic prep1();
      logic [31:0] sum, w;
      exp_t        e;
      sum = 32'd0;
      q1.delete();
      for (int i = 0; i < 4 * D1; i++) img1[i] = 8'($urandom);
      for (int k = 0; k < D1; k++) begin
         w = {img1[4*k+3], img1[4*k+2], img1[4*k+1], img1[4*k]};
         sum += w;
         e.addr = k;
         e.data = w;
         q1.push_back(e);
      end
`ifdef BOOT_CHECKSUM_EN
      for (int b = 0; b < 4; b++) img1[4*D1+b] = 8'(sum >> (8 * b));
`endif
   endtask

   function automatic logic fbit0(input int d);
      if (d / 8 >= NB0) return 1'b0;
      return img0[d/8][7 - (d % 8)];
   endfunction

   function automatic logic fbit1(input int d);
      if (d / 8 >= NB1) return 1'b0;
      return img1[d/8][7 - (d % 8)];
   endfunction

   // ---------------- flash models ----------------
   int          r0 = 0, sess0 = 0, mbad0 = 0, r1 = 0, mbad1 = 0;
   logic [31:0] cmd0 = 32'd0, cmd1 = 32'd0;
   logic        ps0 = 1'b0, pc0 = 1'b1, ps1 = 1'b0, pc1 = 1'b1;

   initial forever begin
      @(negedge clk);
      if (pc0 && !cs_n0) begin r0 = 0; cmd0 = 32'd0; sess0++; end
      if (!cs_n0 && sclk0 && !ps0) begin
         if (r0 < 32) cmd0 = {cmd0[30:0], mosi0};
         else if (mosi0 !== 1'b0) mbad0++;
         r0++;
      end
      if (!cs_n0 && !sclk0 && ps0 && r0 >= 32) miso0 = fbit0(r0 - 32);
      ps0 = sclk0;
      pc0 = cs_n0;
   end

   initial forever begin
      @(negedge clk);
      if (pc1 && !cs_n1) begin r1 = 0; cmd1 = 32'd0; end
      if (!cs_n1 && sclk1 && !ps1) begin
         if (r1 < 32) cmd1 = {cmd1[30:0], mosi1};
         else if (mosi1 !== 1'b0) mbad1++;
         r1++;
      end
      if (!cs_n1 && !sclk1 && ps1 && r1 >= 32) miso1 = fbit1(r1 - 32);
      ps1 = sclk1;
      pc1 = cs_n1;
   end

   // ---------------- write monitors ----------------
   exp_t e0, e1;

   initial forever begin
      @(negedge clk);
      if (we0 === 1'b1) begin
         wr0++;
         if (q0.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL imem0_extra_write: got addr %0d data 0x%08h, required no write", addr0, wdata0);
         end else begin
            e0 = q0.pop_front();
            check("imem0_addr", 32'(addr0), 32'(e0.addr));
            check("imem0_wdata", wdata0, e0.data);
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (we1 === 1'b1) begin
         wr1++;
         if (q1.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL imem1_extra_write: got addr %0d data 0x%08h, required no write", addr1, wdata1);
         end else begin
            e1 = q1.pop_front();
            check("imem1_addr", 32'(addr1), 32'(e1.addr));
            check("imem1_wdata", wdata1, e1.data);
         end
      end
   end

   // ---------------- dut0 helpers ----------------
   task automatic chk_reset0(input string tag);
      check({tag, "_sclk"},  32'(sclk0),  32'd0);
      check({tag, "_cs_n"},  32'(cs_n0),  32'd1);
      check({tag, "_mosi"},  32'(mosi0),  32'd0);
      check({tag, "_we"},    32'(we0),    32'd0);
      check({tag, "_addr"},  32'(addr0),  32'd0);
      check({tag, "_wdata"}, wdata0,      32'd0);
      check({tag, "_crn"},   32'(crn0),   32'd0);
      check({tag, "_done"},  32'(done0),  32'd0);
      check({tag, "_error"}, 32'(err0),   32'd0);
   endtask

   task automatic finish_load0(input string tag, input int sess_exp);
      int sync_bad;
      int c;
      sync_bad = 0;
      for (c = 0; c < 40000 && done0 !== 1'b1; c++) begin
         @(negedge clk);
         if (crn0 !== done0) sync_bad++;
      end
      check({tag, "_done"},        32'(done0),         32'd1);
      check({tag, "_crn"},         32'(crn0),          32'd1);
      check({tag, "_crn_sync"},    32'(sync_bad),      32'd0);
      check({tag, "_error"},       32'(err0),          32'd0);
      check({tag, "_cs_n"},        32'(cs_n0),         32'd1);
      check({tag, "_sclk"},        32'(sclk0),         32'd0);
      check({tag, "_writes"},      32'(wr0 - base0),   32'(D0));
      check({tag, "_queue_empty"}, 32'(q0.size()),     32'd0);
      check({tag, "_cmd"},         cmd0,               CMD_EXP);
      check({tag, "_sessions"},    32'(sess0),         32'(sess_exp));
      check({tag, "_mosi_data"},   32'(mbad0),         32'd0);
   endtask

   task automatic pulse_reset0();
      @(posedge clk);
      #1 reset0 = 1'b1;
      @(posedge clk);
      #1 reset0 = 1'b0;
   endtask

   // ---------------- dut1 sequence ----------------
   bit fin1 = 1'b0;

   initial begin
      int cyc1, f1;
      reset1 = 1'b1;
      prep1();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("d1_reset_cs_n", 32'(cs_n1), 32'd1);
      check("d1_reset_crn",  32'(crn1),  32'd0);
      @(posedge clk);
      #1 reset1 = 1'b0;
      for (cyc1 = 1; cyc1 < 5000; cyc1++) begin
         @(posedge clk);
         #1;
         if (done1 === 1'b1) break;
      end
      f1 = 2 + 2 * DIV1 + 2 * DIV1 * (32 + 32 * (D1 + XW));
      n_vec++;
      if (cyc1 < f1 - 1 || cyc1 > f1 + 1) begin
         n_err++;
         $display("FAIL d1_boot_cycles: got %0d, required %0d +/-1", cyc1, f1);
      end
      @(negedge clk);
      check("d1_crn",         32'(crn1),      32'd1);
      check("d1_error",       32'(err1),      32'd0);
      check("d1_writes",      32'(wr1),       32'(D1));
      check("d1_queue_empty", 32'(q1.size()), 32'd0);
      check("d1_cmd",         cmd1,           CMD_EXP);
      check("d1_mosi_data",   32'(mbad1),     32'd0);
      fin1 = 1'b1;
   end

   // ---------------- dut0 sequence ----------------
   initial begin
      int c;
      reset0 = 1'b1;
      prep0(1'b0, 32'd0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk_reset0("reset");

      // Sequential-byte image, interrupted by reset during word 40.
      @(posedge clk);
      #1 reset0 = 1'b0;
      for (c = 0; c < 30000 && (wr0 - base0) < 40; c++) @(negedge clk);
      check("mid_40_writes", 32'(wr0 - base0), 32'd40);
      repeat (30) @(posedge clk);
      #1 reset0 = 1'b1;
      prep0(1'b0, 32'd0);
      @(posedge clk);
      #1 reset0 = 1'b0;
      @(negedge clk);
      check("mid_reset_cs_n", 32'(cs_n0), 32'd1);
      check("mid_reset_crn",  32'(crn0),  32'd0);
      check("mid_reset_sclk", 32'(sclk0), 32'd0);
      check("mid_reset_addr", 32'(addr0), 32'd0);
      finish_load0("seq", 2);

      // Random image.
      prep0(1'b1, 32'd0);
      pulse_reset0();
      @(negedge clk);
      check("rnd_done_cleared", 32'(done0), 32'd0);
      check("rnd_crn_cleared",  32'(crn0),  32'd0);
      finish_load0("rnd", 3);

`ifdef BOOT_CHECKSUM_EN
      // Checksum word off by one.
      prep0(1'b1, 32'd1);
      pulse_reset0();
      for (c = 0; c < 40000 && err0 !== 1'b1; c++) @(negedge clk);
      check("bad_sum_error", 32'(err0), 32'd1);
      repeat (300) @(negedge clk);
      check("bad_sum_error_sticky", 32'(err0),        32'd1);
      check("bad_sum_crn",          32'(crn0),        32'd0);
      check("bad_sum_done",         32'(done0),       32'd0);
      check("bad_sum_cs_n",         32'(cs_n0),       32'd1);
      check("bad_sum_writes",       32'(wr0 - base0), 32'(D0));
      check("bad_sum_queue_empty",  32'(q0.size()),   32'd0);
`endif

      for (c = 0; c < 20000 && !fin1; c++) @(negedge clk);
      check("d1_finished", 32'(fin1), 32'd1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
